sc2110_roi_crop_module: RTL and testbench

SC2110_ROI_CROP_MODULE -- requirements
Module: sc2110_roi_crop_module

---
 rtl/sc2110_roi_crop_module_pkg.sv | 13 +
 rtl/sc2110_edge_det_module.sv | 21 ++
 rtl/sc2110_roi_crop_module.sv | 149 ++++++++++++++
 tb/tb_sc2110_roi_crop_module.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sc2110_roi_crop_module_pkg.sv
// Shared definitions for the sc2110 ROI crop block: default widths and FSM encoding.
package sc2110_roi_crop_module_pkg;

  localparam int unsigned DW_DEF = 12;
  localparam int unsigned CW_DEF = 12;

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_IDLE  = 2'd1,
    S_FRAME = 2'd2
  } state_t;

endpackage

// File: rtl/sc2110_edge_det_module.sv
// Single-bit edge detector: combinational rise/fall strobes against the previous-cycle level.
module sc2110_edge_det_module (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_c,
  output logic fall_c
);

  logic prev;

  // Remember last cycle's level; cleared so a level high at reset exit reads as a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= d;
  end

  assign rise_c = d & ~prev;
  assign fall_c = ~d & prev;

endmodule

// File: rtl/sc2110_roi_crop_module.sv
// Crops a region of interest out of a CMOS fvld/lvld/dvld pixel stream and measures frame size.
module sc2110_roi_crop_module
  import sc2110_roi_crop_module_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cmos_fvld,
  input  logic          i_cmos_lvld,
  input  logic          i_cmos_dvld,
  input  logic [DW-1:0] i_cmos_data,
  input  logic [CW-1:0] i_roi_x,
  input  logic [CW-1:0] i_roi_y,
  input  logic [CW-1:0] i_roi_w,
  input  logic [CW-1:0] i_roi_h,
  output logic          o_cmos_fvld,
  output logic          o_cmos_lvld,
  output logic          o_cmos_dvld,
  output logic [DW-1:0] o_cmos_data,
  output logic [CW-1:0] o_meas_w,
  output logic [CW-1:0] o_meas_h,
  output logic          o_meas_vld,
  output logic          o_err_short
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state, state_nxt;
  logic          fv_rise, fv_fall, lv_rise, lv_fall;
  logic          dv_rise_unused, dv_fall_unused;
  logic [CW-1:0] x_cnt, y_cnt, line_w;
  logic [CW-1:0] roi_x, roi_y, roi_w, roi_h;

  logic          frame_start_c, frame_act_c, line_end_c, meas_take_c;
  logic          pix_c, in_x_c, in_y_c, keep_c, err_c;
  logic [CW-1:0] rx_c, ry_c, rw_c, rh_c, x_c, y_c, x_inc_c, y_inc_c;
  logic [CW-1:0] meas_w_c, meas_h_c;
  logic [CW:0]   x_hi_c, y_hi_c, need_w_c, need_h_c;

  // Edge strobes for the three sync inputs; dvld edges are not needed by the crop itself.
  sc2110_edge_det_module u_fv_edge (
    .clk(i_clk), .rst(i_rst), .d(i_cmos_fvld), .rise_c(fv_rise), .fall_c(fv_fall)
  );
  sc2110_edge_det_module u_lv_edge (
    .clk(i_clk), .rst(i_rst), .d(i_cmos_lvld), .rise_c(lv_rise), .fall_c(lv_fall)
  );
  sc2110_edge_det_module u_dv_edge (
    .clk(i_clk), .rst(i_rst), .d(i_cmos_dvld), .rise_c(dv_rise_unused), .fall_c(dv_fall_unused)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_SYNC;
    else       state <= state_nxt;
  end

  // Next-state: resync on a quiet fvld, then follow frame boundaries.
  always_comb begin
    state_nxt = state;
    case (state)
      S_SYNC:  if (!i_cmos_fvld) state_nxt = S_IDLE;
      S_IDLE:  if (fv_rise)      state_nxt = S_FRAME;
      S_FRAME: if (fv_fall)      state_nxt = S_IDLE;
      default:                   state_nxt = S_SYNC;
    endcase
  end

  // Window decision; on the frame/line start cycle the freshly cleared counters and new ROI apply.
  always_comb begin
    frame_start_c = (state == S_IDLE) & fv_rise;
    frame_act_c   = (state == S_FRAME) | frame_start_c;
    line_end_c    = (state == S_FRAME) & lv_fall;
    meas_take_c   = (state == S_FRAME) & fv_fall;
    rx_c          = frame_start_c ? i_roi_x : roi_x;
    ry_c          = frame_start_c ? i_roi_y : roi_y;
    rw_c          = frame_start_c ? i_roi_w : roi_w;
    rh_c          = frame_start_c ? i_roi_h : roi_h;
    x_c           = lv_rise ? '0 : x_cnt;
    y_c           = frame_start_c ? '0 : y_cnt;
    x_inc_c       = (x_c == CNT_MAX) ? CNT_MAX : x_c + CW'(1);
    y_inc_c       = (y_cnt == CNT_MAX) ? CNT_MAX : y_cnt + CW'(1);
    x_hi_c        = {1'b0, rx_c} + {1'b0, rw_c};
    y_hi_c        = {1'b0, ry_c} + {1'b0, rh_c};
    in_x_c        = ({1'b0, x_c} >= {1'b0, rx_c}) && ({1'b0, x_c} < x_hi_c);
    in_y_c        = ({1'b0, y_c} >= {1'b0, ry_c}) && ({1'b0, y_c} < y_hi_c);
    pix_c         = i_cmos_fvld & i_cmos_lvld & i_cmos_dvld;
    keep_c        = frame_act_c & pix_c & in_x_c & in_y_c;
    meas_w_c      = line_end_c ? x_cnt : line_w;
    meas_h_c      = line_end_c ? y_inc_c : y_cnt;
    need_w_c      = {1'b0, roi_x} + {1'b0, roi_w};
    need_h_c      = {1'b0, roi_y} + {1'b0, roi_h};
    err_c         = ({1'b0, meas_w_c} < need_w_c) | ({1'b0, meas_h_c} < need_h_c);
  end

  // Pixel/line counters, last line width and per-frame ROI latch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_cnt  <= '0;
      y_cnt  <= '0;
      line_w <= '0;
      roi_x  <= '0;
      roi_y  <= '0;
      roi_w  <= '0;
      roi_h  <= '0;
    end else begin
      if (pix_c)        x_cnt <= x_inc_c;
      else if (lv_rise) x_cnt <= '0;
      if (frame_start_c) begin
        y_cnt  <= '0;
        line_w <= '0;
        roi_x  <= i_roi_x;
        roi_y  <= i_roi_y;
        roi_w  <= i_roi_w;
        roi_h  <= i_roi_h;
      end else if (line_end_c) begin
        y_cnt  <= y_inc_c;
        line_w <= x_cnt;
      end
    end
  end

  // Registered cropped stream and end-of-frame measurement.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cmos_fvld <= 1'b0;
      o_cmos_lvld <= 1'b0;
      o_cmos_dvld <= 1'b0;
      o_cmos_data <= '0;
      o_meas_w    <= '0;
      o_meas_h    <= '0;
      o_meas_vld  <= 1'b0;
      o_err_short <= 1'b0;
    end else begin
      o_cmos_fvld <= frame_act_c & i_cmos_fvld;
      o_cmos_lvld <= frame_act_c & i_cmos_lvld & in_y_c & (rw_c != '0);
      o_cmos_dvld <= keep_c;
      if (keep_c) o_cmos_data <= i_cmos_data;
      o_meas_vld  <= meas_take_c;
      o_err_short <= meas_take_c & err_c;
      if (meas_take_c) begin
        o_meas_w <= meas_w_c;
        o_meas_h <= meas_h_c;
      end
    end
  end

endmodule

// File: tb/tb_sc2110_roi_crop_module.sv
// Self-checking bench for sc2110_roi_crop_module: directed table, frame-level model, random frames.
module tb_sc2110_roi_crop_module;

  logic        clk = 1'b0;
  logic        rst;
  logic        fvld, lvld, dvld;
  logic [11:0] data;
  logic [11:0] roi_x, roi_y, roi_w, roi_h;
  logic        o_fvld, o_lvld, o_dvld, o_mvld, o_err;
  logic [11:0] o_data, o_mw, o_mh;

  int nchk = 0;
  int nerr = 0;
  int out_pix = 0;

  // Model state: ROI seen at the frame start and the last kept pixel value.
  int lx, ly, lw, lh;
  int cx, cy, cw, ch;
  logic [11:0] m_data;

  typedef struct {
    logic fv, lv, dv;
    logic [11:0] d;
    logic e_fv, e_lv, e_dv;
    logic [11:0] e_d;
    logic e_mv;
    int   e_mw, e_mh;
    logic e_err;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  sc2110_roi_crop_module dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmos_fvld(fvld), .i_cmos_lvld(lvld), .i_cmos_dvld(dvld), .i_cmos_data(data),
    .i_roi_x(roi_x), .i_roi_y(roi_y), .i_roi_w(roi_w), .i_roi_h(roi_h),
    .o_cmos_fvld(o_fvld), .o_cmos_lvld(o_lvld), .o_cmos_dvld(o_dvld), .o_cmos_data(o_data),
    .o_meas_w(o_mw), .o_meas_h(o_mh), .o_meas_vld(o_mvld), .o_err_short(o_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic fv, lv, dv, input logic [11:0] d,
                              input logic efv, elv, edv, input logic [11:0] ed,
                              input logic emv, input int emw, emh, input logic eerr);
    vec_t v;
    v.fv = fv; v.lv = lv; v.dv = dv; v.d = d;
    v.e_fv = efv; v.e_lv = elv; v.e_dv = edv; v.e_d = ed;
    v.e_mv = emv; v.e_mw = emw; v.e_mh = emh; v.e_err = eerr;
    return v;
  endfunction

  task automatic set_roi(input int x, y, w, h);
    cx = x; cy = y; cw = w; ch = h;
    roi_x = 12'(x); roi_y = 12'(y); roi_w = 12'(w); roi_h = 12'(h);
  endtask

  // Drive one cycle of inputs and compare the outputs registered at the following edge.
  task automatic apply(input vec_t v);
    fvld = v.fv; lvld = v.lv; dvld = v.dv; data = v.d;
    @(posedge clk);
    #1;
    out_pix += int'(o_dvld);
    chk("fvld", 32'(o_fvld), 32'(v.e_fv));
    chk("lvld", 32'(o_lvld), 32'(v.e_lv));
    chk("dvld", 32'(o_dvld), 32'(v.e_dv));
    chk("data", 32'(o_data), 32'(v.e_d));
    chk("meas_vld", 32'(o_mvld), 32'(v.e_mv));
    chk("err_short", 32'(o_err), 32'(v.e_err));
    if (v.e_mv) begin
      chk("meas_w", 32'(o_mw), 32'(v.e_mw));
      chk("meas_h", 32'(o_mh), 32'(v.e_mh));
    end
  endtask

  // One stream cycle; c is the column index of a valid pixel (or -1), y the line index.
  task automatic mcyc(input logic fv, lv, dv, input int y, c, input bit emit);
    vec_t v;
    logic [11:0] d;
    int xs;
    bit in_y, keep;
    d = 12'($urandom);
    xs = (c > 4095) ? 4095 : c;
    in_y = (y >= ly) && (y < ly + lh);
    v = mk(fv, lv, dv, d, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 0, 0, 1'b0);
    v.e_fv = emit && fv;
    v.e_lv = emit && fv && lv && in_y && (lw > 0);
    keep = v.e_lv && dv && (c >= 0) && (xs >= lx) && (xs < lx + lw);
    if (keep) m_data = d;
    v.e_dv = keep;
    v.e_d = m_data;
    apply(v);
  endtask

  task automatic frame_start(input bit emit);
    lx = cx; ly = cy; lw = cw; lh = ch;
    mcyc(1'b1, 1'b0, 1'b0, 0, -1, emit);
  endtask

  task automatic line(input int y, w, input bit emit, gaps, merge);
    for (int c = 0; c < w; c++) begin
      if (gaps && $urandom_range(0, 3) == 0) mcyc(1'b1, 1'b1, 1'b0, y, -1, emit);
      mcyc(1'b1, 1'b1, 1'b1, y, c, emit);
    end
    if (!merge) begin
      int hb;
      hb = 1 + $urandom_range(0, 1);
      for (int i = 0; i < hb; i++) mcyc(1'b1, 1'b0, 1'b0, y, -1, emit);
    end
  endtask

  // fvld falling cycle carries the measurement; optional quiet cycle afterwards.
  task automatic frame_end(input int w, h, input bit emit, tail);
    vec_t v;
    int mw;
    mw = (w > 4095) ? 4095 : w;
    v = mk(1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, m_data, emit, mw, h, 1'b0);
    v.e_err = emit && ((mw < lx + lw) || (h < ly + lh));
    apply(v);
    if (tail) mcyc(1'b0, 1'b0, 1'b0, 0, -1, 1'b0);
  endtask

  task automatic frame(input int w, h, input bit gaps, merge, tail);
    frame_start(1'b1);
    for (int y = 0; y < h; y++) line(y, w, 1'b1, gaps, merge && (y == h - 1));
    frame_end(w, h, 1'b1, tail);
  endtask

  initial begin
    rst = 1'b1;
    fvld = 1'b0; lvld = 1'b0; dvld = 1'b0; data = '0;
    set_roi(1, 1, 2, 1);
    m_data = '0;
    lx = 0; ly = 0; lw = 0; lh = 0;

    // Tiny 3x2 frame, ROI x=1 y=1 w=2 h=1, lvld and fvld fall together at the end.
    tbl[0]  = mk(0,0,0,12'h000, 0,0,0,12'h000, 0,0,0,0);
    tbl[1]  = mk(1,0,0,12'h000, 1,0,0,12'h000, 0,0,0,0);
    tbl[2]  = mk(1,1,1,12'h010, 1,0,0,12'h000, 0,0,0,0);
    tbl[3]  = mk(1,1,1,12'h011, 1,0,0,12'h000, 0,0,0,0);
    tbl[4]  = mk(1,1,1,12'h012, 1,0,0,12'h000, 0,0,0,0);
    tbl[5]  = mk(1,0,0,12'h000, 1,0,0,12'h000, 0,0,0,0);
    tbl[6]  = mk(1,1,1,12'h020, 1,1,0,12'h000, 0,0,0,0);
    tbl[7]  = mk(1,1,1,12'h021, 1,1,1,12'h021, 0,0,0,0);
    tbl[8]  = mk(1,1,1,12'h022, 1,1,1,12'h022, 0,0,0,0);
    tbl[9]  = mk(0,0,0,12'h000, 0,0,0,12'h022, 1,3,2,0);
    tbl[10] = mk(0,0,0,12'h000, 0,0,0,12'h022, 0,0,0,0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_fvld", 32'(o_fvld), 32'd0);
    chk("rst_dvld", 32'(o_dvld), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_meas_w", 32'(o_mw), 32'd0);
    chk("rst_meas_vld", 32'(o_mvld), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) apply(tbl[i]);
    m_data = 12'h022;

    // 64x8, ROI 4,2,8,3: 24 pixels, full size measured.
    set_roi(4, 2, 8, 3);
    out_pix = 0;
    frame(64, 8, 1'b0, 1'b0, 1'b1);
    chk("pix_64x8", 32'(out_pix), 32'd24);

    // ROI past the right/bottom edge: 4x2 pixels and short-frame error.
    set_roi(60, 6, 8, 4);
    out_pix = 0;
    frame(64, 8, 1'b1, 1'b0, 1'b0);
    chk("pix_short", 32'(out_pix), 32'd8);

    // ROI changed mid-frame takes effect only at the next frame.
    set_roi(4, 2, 8, 3);
    out_pix = 0;
    frame_start(1'b1);
    line(0, 64, 1'b1, 1'b0, 1'b0);
    set_roi(0, 2, 64, 3);
    for (int y = 1; y < 8; y++) line(y, 64, 1'b1, 1'b0, 1'b0);
    frame_end(64, 8, 1'b1, 1'b1);
    chk("pix_old_roi", 32'(out_pix), 32'd24);
    out_pix = 0;
    frame(64, 8, 1'b0, 1'b1, 1'b1);
    chk("pix_new_roi", 32'(out_pix), 32'd192);

    // Zero-width ROI: frame valid still passes, no pixels.
    set_roi(2, 0, 0, 4);
    out_pix = 0;
    frame(10, 4, 1'b0, 1'b1, 1'b0);
    chk("pix_w0", 32'(out_pix), 32'd0);

    // Reset in the middle of a frame, released while that frame is still running.
    set_roi(4, 2, 8, 3);
    frame_start(1'b1);
    line(0, 64, 1'b1, 1'b0, 1'b0);
    line(1, 64, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) mcyc(1'b1, 1'b1, 1'b1, 2, c, 1'b1);
    #2 rst = 1'b1;
    #1;
    m_data = '0;
    chk("async_rst_fvld", 32'(o_fvld), 32'd0);
    chk("async_rst_lvld", 32'(o_lvld), 32'd0);
    chk("async_rst_data", 32'(o_data), 32'd0);
    chk("async_rst_meas_h", 32'(o_mh), 32'd0);
    for (int c = 20; c < 23; c++) mcyc(1'b1, 1'b1, 1'b1, 2, c, 1'b0);
    rst = 1'b0;
    out_pix = 0;
    for (int c = 23; c < 64; c++) mcyc(1'b1, 1'b1, 1'b1, 2, c, 1'b0);
    mcyc(1'b1, 1'b0, 1'b0, 2, -1, 1'b0);
    for (int y = 3; y < 8; y++) line(y, 64, 1'b0, 1'b0, 1'b0);
    frame_end(64, 8, 1'b0, 1'b0);
    chk("pix_after_rst", 32'(out_pix), 32'd0);
    out_pix = 0;
    frame(64, 8, 1'b0, 1'b0, 1'b1);
    chk("pix_next_frame", 32'(out_pix), 32'd24);

    // Line longer than the counter range: column count saturates.
    set_roi(4090, 0, 10, 1);
    out_pix = 0;
    frame(4100, 1, 1'b0, 1'b0, 1'b1);
    chk("pix_sat", 32'(out_pix), 32'd10);

    // Random frames and ROIs, some back-to-back, some with ROI changes mid-frame.
    for (int n = 0; n < 30; n++) begin
      int w, h;
      bit merge, tail;
      w = $urandom_range(1, 20);
      h = $urandom_range(1, 6);
      merge = 1'($urandom_range(0, 1));
      tail = 1'($urandom_range(0, 1));
      set_roi($urandom_range(0, w + 1), $urandom_range(0, h), $urandom_range(0, w), $urandom_range(0, h));
      frame_start(1'b1);
      for (int y = 0; y < h; y++) begin
        line(y, w, 1'b1, 1'b1, merge && (y == h - 1));
        if (y == 0 && $urandom_range(0, 2) == 0)
          set_roi($urandom_range(0, w), $urandom_range(0, h), $urandom_range(0, w), $urandom_range(0, h));
      end
      frame_end(w, h, 1'b1, tail);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
